// File: rtl/md_issue_ctrl.sv
// Issue controller for the multiply/divide unit in E.
// Stalls E while HI/LO are pending and blocks issue on flush.
module md_issue_ctrl #(
  parameter int unsigned MUL_CYCLES  = 4,
  parameter int unsigned DIV_CYCLES  = 9,
  parameter int unsigned DRAIN_LIMIT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        e_valid,
  input  logic [2:0]  e_md_op,
  input  logic        e_is_mf,
  input  logic        flush,
  input  logic        unit_busy,
  output logic        md_start,
  output logic [2:0]  md_ctr,
  output logic        md_lock,
  output logic        stall_e,
  output logic [15:0] stall_cnt,
  output logic        md_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam logic [3:0] MUL_LD   = 4'(MUL_CYCLES - 1);
  localparam logic [3:0] DIV_LD   = 4'(DIV_CYCLES - 1);
  localparam logic [3:0] DRN_LAST = 4'(DRAIN_LIMIT - 1);
  localparam logic [2:0] CTR_NONE = 3'b110;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  dcnt_q, dcnt_d;
  logic        err_q, err_d;
  logic        idle_busy_q, idle_busy_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  logic start_op;
  logic mt_op;
  logic md_use;
  logic hazard;

  always_comb begin
    start_op = ~e_md_op[2];
    mt_op    = e_md_op[2] & ~e_md_op[1];
    md_use   = e_valid & (start_op | mt_op | e_is_mf);
    hazard   = (state_q != IDLE) | unit_busy;
    stall_e  = md_use & hazard & ~flush;
    md_start = e_valid & start_op & ~hazard & ~flush;
    md_lock  = flush | hazard | ~e_valid;
    md_ctr   = e_valid ? e_md_op : CTR_NONE;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dcnt_d      = dcnt_q;
    err_d       = err_q;
    idle_busy_d = 1'b0;
    stall_cnt_d = stall_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (md_start) begin
          state_d = RUN;
          cnt_d   = e_md_op[1] ? DIV_LD : MUL_LD;
        end
      end
      RUN: begin
        if (cnt_q == 4'd0) begin
          if (unit_busy) begin
            state_d = DRAIN;
            dcnt_d  = 4'd0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DRAIN: begin
        if (!unit_busy) begin
          state_d = IDLE;
        end else if (dcnt_q == DRN_LAST) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          dcnt_d = dcnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    // unit claims busy although nothing was issued to it
    idle_busy_d = (state_q == IDLE) & unit_busy & ~md_start;
    if (idle_busy_d && idle_busy_q) begin
      err_d = 1'b1;
    end
    if (stall_e && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      dcnt_q      <= 4'd0;
      err_q       <= 1'b0;
      idle_busy_q <= 1'b0;
      stall_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dcnt_q      <= dcnt_d;
      err_q       <= err_d;
      idle_busy_q <= idle_busy_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign md_err    = err_q;

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Bench for md_issue_ctrl: directed scenarios plus random
// instruction streams against a cycle-window reference model.
module tb_md_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        e_valid;
  logic [2:0]  e_md_op;
  logic        e_is_mf;
  logic        flush;
  logic        unit_busy;
  logic        md_start;
  logic [2:0]  md_ctr;
  logic        md_lock;
  logic        stall_e;
  logic [15:0] stall_cnt;
  logic        md_err;

  md_issue_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .e_valid   (e_valid),
    .e_md_op   (e_md_op),
    .e_is_mf   (e_is_mf),
    .flush     (flush),
    .unit_busy (unit_busy),
    .md_start  (md_start),
    .md_ctr    (md_ctr),
    .md_lock   (md_lock),
    .stall_e   (stall_e),
    .stall_cnt (stall_cnt),
    .md_err    (md_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // model: absolute cycle windows
  int cyc = 0;
  int ctrl_end = 0;
  int busy_end = 0;
  int err_from = 32'h7fffffff;
  int sc = 0;
  bit prev_ib = 1'b0;
  bit prev_ub = 1'b0;
  bit last_stall = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    ctrl_end = cyc;
    busy_end = cyc;
    err_from = 32'h7fffffff;
    sc       = 0;
    prev_ib  = 1'b0;
    prev_ub  = 1'b0;
  endtask

  task automatic run_cycle(input logic v, input logic [2:0] op,
                           input logic mf, input logic fl,
                           input int stretch, input bit spur,
                           input bit force_b);
    bit ub, haz, use_md, es, est, elk, ib;
    int lat;
    @(posedge clk);
    #1;
    cyc++;
    ub = (cyc <= busy_end) || force_b ||
         (spur && !prev_ub && cyc > ctrl_end && cyc > busy_end);
    e_valid   = v;
    e_md_op   = op;
    e_is_mf   = mf;
    flush     = fl;
    unit_busy = ub;
    haz    = (cyc <= ctrl_end) || ub;
    use_md = v && (op < 3'd6 || mf);
    est    = use_md && haz && !fl;
    es     = v && (op < 3'd4) && !haz && !fl;
    elk    = fl || haz || !v;
    @(negedge clk);
    chk("md_start", {31'd0, md_start}, {31'd0, es});
    chk("stall_e", {31'd0, stall_e}, {31'd0, est});
    chk("md_lock", {31'd0, md_lock}, {31'd0, elk});
    chk("md_ctr", {29'd0, md_ctr}, v ? {29'd0, op} : 32'd6);
    chk("stall_cnt", {16'd0, stall_cnt}, sc);
    chk("md_err", {31'd0, md_err}, (cyc >= err_from) ? 32'd1 : 32'd0);
    if (est && sc < 65535) sc++;
    ib = (cyc > ctrl_end) && ub && !es;
    if (ib && prev_ib && err_from > cyc + 1) err_from = cyc + 1;
    prev_ib = ib;
    prev_ub = ub;
    if (es) begin
      lat      = op[1] ? 9 : 4;
      busy_end = cyc + lat - 1 + stretch;
      ctrl_end = cyc + lat + ((stretch > 15) ? 15 : stretch);
      if (stretch > 15 && err_from > cyc + lat + 16)
        err_from = cyc + lat + 16;
    end
    last_stall = est;
  endtask

  // asynchronous reset from mid-cycle; state must drop at once
  task automatic apply_reset();
    #1;
    reset     = 1'b0;
    e_valid   = 1'b1;
    e_md_op   = 3'b110;
    e_is_mf   = 1'b1;
    flush     = 1'b0;
    unit_busy = 1'b0;
    #1;
    chk("rst_lock", {31'd0, md_lock}, 32'd0);
    chk("rst_stall", {31'd0, stall_e}, 32'd0);
    chk("rst_start", {31'd0, md_start}, 32'd0);
    chk("rst_cnt", {16'd0, stall_cnt}, 32'd0);
    chk("rst_err", {31'd0, md_err}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  task automatic wait_idle(output int k);
    k = 0;
    do begin
      run_cycle(1'b1, 3'b110, 1'b0, 1'b0, 0, 1'b0, 1'b0);
      k++;
    end while (md_lock && k < 60);
    if (k >= 60) chk("wait_idle_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    int k;
    logic v, mf, fl;
    logic [2:0] op;
    int r, st;
    bit sp;

    reset     = 1'b0;
    e_valid   = 1'b0;
    e_md_op   = 3'b110;
    e_is_mf   = 1'b0;
    flush     = 1'b0;
    unit_busy = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("inrst_lock", {31'd0, md_lock}, 32'd1);
      chk("inrst_start", {31'd0, md_start}, 32'd0);
      chk("inrst_stall", {31'd0, stall_e}, 32'd0);
      chk("inrst_ctr", {29'd0, md_ctr}, 32'd6);
    end
    reset = 1'b1;
    run_cycle(1'b0, 3'b110, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    run_cycle(1'b0, 3'b110, 1'b0, 1'b0, 0, 1'b0, 1'b0);

    // mult then mfhi
    run_cycle(1'b1, 3'b000, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    chk("mult_start", {31'd0, md_start}, 32'd1);
    k = 0;
    do begin
      run_cycle(1'b1, 3'b110, 1'b1, 1'b0, 0, 1'b0, 1'b0);
      if (stall_e) k++;
    end while (stall_e && k < 30);
    chk("mfhi_stall_len", k, 32'd4);
    chk("mfhi_stall_cnt", {16'd0, stall_cnt}, 32'd4);

    // divu then mtlo
    run_cycle(1'b1, 3'b011, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    chk("divu_start", {31'd0, md_start}, 32'd1);
    k = 0;
    do begin
      run_cycle(1'b1, 3'b101, 1'b0, 1'b0, 0, 1'b0, 1'b0);
      if (stall_e) begin
        k++;
        chk("mtlo_locked", {31'd0, md_lock}, 32'd1);
      end
    end while (stall_e && k < 30);
    chk("mtlo_stall_len", k, 32'd9);
    chk("mtlo_release_lock", {31'd0, md_lock}, 32'd0);

    // flush blocks issue, next cycle issues
    run_cycle(1'b1, 3'b010, 1'b0, 1'b1, 0, 1'b0, 1'b0);
    chk("flush_start", {31'd0, md_start}, 32'd0);
    chk("flush_lock", {31'd0, md_lock}, 32'd1);
    run_cycle(1'b1, 3'b000, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    chk("post_flush_start", {31'd0, md_start}, 32'd1);
    wait_idle(k);
    chk("post_flush_idle", k - 1, 32'd4);

    // unit overruns by 3, then by exactly the drain limit
    run_cycle(1'b1, 3'b000, 1'b0, 1'b0, 3, 1'b0, 1'b0);
    wait_idle(k);
    chk("drain3_lock_cycles", k - 1, 32'd7);
    chk("drain3_err", {31'd0, md_err}, 32'd0);
    run_cycle(1'b1, 3'b001, 1'b0, 1'b0, 15, 1'b0, 1'b0);
    wait_idle(k);
    chk("drain15_lock_cycles", k - 1, 32'd19);
    chk("drain15_err", {31'd0, md_err}, 32'd0);

    // reset while a div is in flight
    run_cycle(1'b1, 3'b010, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    run_cycle(1'b1, 3'b110, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    run_cycle(1'b1, 3'b110, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    apply_reset();

    // random instruction stream
    v  = 1'b1;
    op = 3'($urandom % 8);
    mf = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      fl = (($urandom % 16) == 0);
      r  = int'($urandom % 16);
      st = (r < 10) ? 0 : (r < 13) ? r - 9 : (r == 13) ? 15 : 5;
      sp = (($urandom % 12) == 0);
      run_cycle(v, op, mf, fl, st, sp, 1'b0);
      if (fl || !last_stall) begin
        v  = (($urandom % 4) != 0);
        op = 3'($urandom % 8);
        mf = (op >= 3'd6) && (($urandom % 2) == 1);
      end
    end

    // single stray busy cycle is tolerated
    wait_idle(k);
    run_cycle(1'b1, 3'b110, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    run_cycle(1'b1, 3'b110, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    run_cycle(1'b1, 3'b110, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    chk("stray1_err", {31'd0, md_err}, 32'd0);

    // drain timeout
    run_cycle(1'b1, 3'b000, 1'b0, 1'b0, 20, 1'b0, 1'b0);
    wait_idle(k);
    chk("timeout_lock_cycles", k - 1, 32'd23);
    chk("timeout_err", {31'd0, md_err}, 32'd1);
    repeat (3) run_cycle(1'b1, 3'b110, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    chk("timeout_err_sticky", {31'd0, md_err}, 32'd1);

    // stray busy for two idle cycles
    apply_reset();
    run_cycle(1'b1, 3'b110, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    run_cycle(1'b1, 3'b110, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    run_cycle(1'b1, 3'b110, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    chk("stray2_err", {31'd0, md_err}, 32'd1);

    // stall counter saturation
    for (int i = 0; i < 70000; i++)
      run_cycle(1'b1, 3'b110, 1'b1, 1'b0, 0, 1'b0, 1'b1);
    chk("stall_cnt_sat", {16'd0, stall_cnt}, 32'h0000FFFF);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
